// File: rtl/eflags_pkg.sv
// Shared EFLAGS definitions: 6-bit flag vector layout, EFLAGS bit positions, reset value.
package eflags_pkg;

  // Index within the 6-bit {OF,SF,ZF,AF,PF,CF} vector
  localparam int CF_IDX = 0;
  localparam int PF_IDX = 1;
  localparam int AF_IDX = 2;
  localparam int ZF_IDX = 3;
  localparam int SF_IDX = 4;
  localparam int OF_IDX = 5;

  // Bit position within the 32-bit EFLAGS register
  localparam int CF_POS = 0;
  localparam int PF_POS = 2;
  localparam int AF_POS = 4;
  localparam int ZF_POS = 6;
  localparam int SF_POS = 7;
  localparam int DF_POS = 10;
  localparam int OF_POS = 11;

  typedef logic [5:0] flag_vec_t;

  localparam logic [31:0] EFLAGS_RST_VAL  = 32'h0000_0002;
  localparam logic [31:0] EFLAGS_ONE_MASK = 32'h0000_0002;
  // Writable bits: CF, PF, AF, ZF, SF, DF, OF
  localparam logic [31:0] EFLAGS_DEF_MASK = 32'h0000_0CD5;

endpackage

// File: rtl/eflags_merge.sv
// Combinational per-bit merge of a loaded flag vector and DF into a 32-bit EFLAGS value.
// Shared by the commit path and the snapshot-capture path; en=0 passes cur through.
module eflags_merge
  import eflags_pkg::*;
(
  input  logic [31:0] cur,
  input  logic        en,
  input  flag_vec_t   src,
  input  flag_vec_t   ld,
  input  logic        ld_df,
  input  logic        df_val,
  output logic [31:0] merged
);

  always_comb begin
    merged = cur;
    if (en) begin
      if (ld[CF_IDX]) merged[CF_POS] = src[CF_IDX];
      if (ld[PF_IDX]) merged[PF_POS] = src[PF_IDX];
      if (ld[AF_IDX]) merged[AF_POS] = src[AF_IDX];
      if (ld[ZF_IDX]) merged[ZF_POS] = src[ZF_IDX];
      if (ld[SF_IDX]) merged[SF_POS] = src[SF_IDX];
      if (ld[OF_IDX]) merged[OF_POS] = src[OF_IDX];
      if (ld_df)      merged[DF_POS] = df_val;
    end
    // Reserved bits: bit 1 reads 1, all others read 0
    merged = (merged & EFLAGS_DEF_MASK) | EFLAGS_ONE_MASK;
  end

endmodule

// File: rtl/eflags_wb.sv
// EX/WB stage register plus architectural EFLAGS commit, DF update and CF/AF/DF forwarding.
// Optional ISR snapshot/restore shadow register is built when EFLAGS_FLAG_SNAPSHOT_EN is defined.
module eflags_wb
  import eflags_pkg::*;
#(
  parameter logic [31:0] EFLAGS_RST = EFLAGS_RST_VAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  flag_vec_t   alu1_flags,
  input  flag_vec_t   cmps_flags,
  input  logic        cmps_sel,
  input  flag_vec_t   ld_flags,
  input  logic        ld_df,
  input  logic        df_val_ex,
  input  logic        wb_stall,
  input  logic        flush,
  input  logic        isr_entry,
  input  logic        isr_restore,
  output logic [31:0] eflags,
  output logic        CF_in,
  output logic        AF_in,
  output logic        DF_in
);

  localparam logic [31:0] RST_VAL = (EFLAGS_RST & EFLAGS_DEF_MASK) | EFLAGS_ONE_MASK;

  logic        wb_valid;
  flag_vec_t   wb_src;
  flag_vec_t   wb_ld;
  logic        wb_ld_df;
  logic        wb_df_val;
  logic [31:0] eflags_q;
  logic [31:0] merged;
  logic        xfer;
  logic        commit;

  assign ex_ready = !flush && (!wb_valid || !wb_stall);
  assign xfer     = ex_valid && ex_ready;
  assign commit   = wb_valid && !wb_stall && !flush;

  eflags_merge u_merge (
    .cur    (eflags_q),
    .en     (commit),
    .src    (wb_src),
    .ld     (wb_ld),
    .ld_df  (wb_ld_df),
    .df_val (wb_df_val),
    .merged (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_src    <= '0;
      wb_ld     <= '0;
      wb_ld_df  <= 1'b0;
      wb_df_val <= 1'b0;
    end else begin
      // A same-cycle accept wins over the retiring entry: full throughput
      if (flush)       wb_valid <= 1'b0;
      else if (xfer)   wb_valid <= 1'b1;
      else if (commit) wb_valid <= 1'b0;
      if (xfer) begin
        wb_src    <= cmps_sel ? cmps_flags : alu1_flags;
        wb_ld     <= ld_flags;
        wb_ld_df  <= ld_df;
        wb_df_val <= df_val_ex;
      end
    end
  end

`ifdef EFLAGS_FLAG_SNAPSHOT_EN
  logic [31:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            shadow <= RST_VAL;
    else if (isr_entry && !isr_restore) shadow <= merged;
  end

  // Restore overrides a coincident commit; the entry still retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              eflags_q <= RST_VAL;
    else if (isr_restore) eflags_q <= shadow;
    else                  eflags_q <= merged;
  end
`else
  logic unused_isr;
  assign unused_isr = isr_entry ^ isr_restore;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) eflags_q <= RST_VAL;
    else     eflags_q <= merged;
  end
`endif

  assign eflags = eflags_q;

  assign CF_in = (wb_valid && wb_ld[CF_IDX] && !flush) ? wb_src[CF_IDX] : eflags_q[CF_POS];
  assign AF_in = (wb_valid && wb_ld[AF_IDX] && !flush) ? wb_src[AF_IDX] : eflags_q[AF_POS];
  assign DF_in = (wb_valid && wb_ld_df && !flush)      ? wb_df_val      : eflags_q[DF_POS];

endmodule

// File: tb/tb_eflags_wb.sv
// Randomized scoreboard bench for eflags_wb against a flag-level reference model.
module tb_eflags_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [5:0]  alu1_flags = '0;
  logic [5:0]  cmps_flags = '0;
  logic        cmps_sel = 1'b0;
  logic [5:0]  ld_flags = '0;
  logic        ld_df = 1'b0;
  logic        df_val_ex = 1'b0;
  logic        wb_stall = 1'b0;
  logic        flush = 1'b0;
  logic        isr_entry = 1'b0;
  logic        isr_restore = 1'b0;
  logic [31:0] eflags;
  logic        CF_in, AF_in, DF_in;

  always #5 clk = ~clk;

  eflags_wb dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu1_flags(alu1_flags), .cmps_flags(cmps_flags), .cmps_sel(cmps_sel),
    .ld_flags(ld_flags), .ld_df(ld_df), .df_val_ex(df_val_ex),
    .wb_stall(wb_stall), .flush(flush), .isr_entry(isr_entry), .isr_restore(isr_restore),
    .eflags(eflags), .CF_in(CF_in), .AF_in(AF_in), .DF_in(DF_in)
  );

  typedef struct packed {
    logic        rdy;
    logic        cf;
    logic        af;
    logic        df;
    logic [31:0] ef;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: one pending result and the architectural register
  logic        m_vld;
  logic [5:0]  m_src, m_ld;
  logic        m_ldf, m_dfv;
  logic [31:0] m_ef, m_snap;
  int          pos[6] = '{0, 2, 4, 6, 7, 11};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_src = '0; m_ld = '0; m_ldf = 1'b0; m_dfv = 1'b0;
    m_ef = 32'h2; m_snap = 32'h2;
  endtask

  task automatic step(input logic r, v, sel, input logic [5:0] a1, cm, ld,
                      input logic ldf, dfv, stall, fl, ie, ir);
    exp_t        e;
    logic        commit, xfer;
    logic [31:0] after;
    @(posedge clk);
    #2;
    rst = r; ex_valid = v; cmps_sel = sel; alu1_flags = a1; cmps_flags = cm;
    ld_flags = ld; ld_df = ldf; df_val_ex = dfv; wb_stall = stall; flush = fl;
    isr_entry = ie; isr_restore = ir;
    if (r) model_reset();
    e.rdy = !fl && !(m_vld && stall);
    e.cf  = (m_vld && m_ld[0] && !fl) ? m_src[0] : m_ef[0];
    e.af  = (m_vld && m_ld[2] && !fl) ? m_src[2] : m_ef[4];
    e.df  = (m_vld && m_ldf && !fl) ? m_dfv : m_ef[10];
    e.ef  = m_ef;
    q.push_back(e);
    if (!r) begin
      commit = m_vld && !stall && !fl;
      xfer   = v && e.rdy;
      after  = m_ef;
      if (commit) begin
        for (int i = 0; i < 6; i++) if (m_ld[i]) after[pos[i]] = m_src[i];
        if (m_ldf) after[10] = m_dfv;
      end
`ifdef EFLAGS_FLAG_SNAPSHOT_EN
      if (ie && !ir) m_snap = after;
      m_ef = ir ? m_snap : after;
`else
      m_ef = after;
`endif
      if (fl) m_vld = 1'b0;
      else if (xfer) begin
        m_vld = 1'b1; m_src = sel ? cm : a1; m_ld = ld; m_ldf = ldf; m_dfv = dfv;
      end else if (commit) m_vld = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares each cycle's presented outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #6;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ex_ready", {31'b0, ex_ready}, {31'b0, e.rdy});
        check("CF_in",    {31'b0, CF_in},    {31'b0, e.cf});
        check("AF_in",    {31'b0, AF_in},    {31'b0, e.af});
        check("DF_in",    {31'b0, DF_in},    {31'b0, e.df});
        check("eflags",   eflags,            e.ef);
      end
    end
  end

  initial begin
    model_reset();
    step(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // CF-only load from ALU1
    step(0, 1, 0, 6'h3F, 6'h00, 6'h01, 0, 0, 0, 0, 0, 0);
    idle(2);
    // CMPS path, ZF only set, all flags loaded
    step(0, 1, 1, 6'h3F, 6'h08, 6'h3F, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Stall for three cycles, then back-to-back accept on release
    step(0, 1, 0, 6'h01, 6'h00, 6'h01, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 6'h10, 6'h00, 6'h10, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 6'h10, 6'h00, 6'h10, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 6'h10, 6'h00, 6'h10, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 6'h10, 6'h00, 6'h10, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Flush a pending DF=1 load
    step(0, 1, 0, 6'h00, 6'h00, 6'h00, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 6'h00, 6'h00, 6'h00, 1, 1, 0, 1, 0, 0);
    idle(2);
    // Snapshot / restore sequence (ignored when the feature is not built)
    step(0, 1, 0, 6'h31, 6'h00, 6'h3F, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 6'h08, 6'h00, 6'h09, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // Random traffic including stalls, flushes, ISR events and rare resets
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           6'($urandom), 6'($urandom), 6'($urandom),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0);
    end
    idle(2);
    @(posedge clk);
    #8;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
